// File: rtl/dds_reg_bank.sv
// Double-buffered DDS parameter bank: host writes go to shadow entries, and dirty entries move to
// active on the first sync_i after a commit. Optional readback port is built with DDS_REG_BANK_READBACK_EN.
module dds_reg_bank #(
    parameter int unsigned        DATA_W   = 8,
    parameter int unsigned        NUM_REGS = 4,
    parameter logic [DATA_W-1:0]  RST_VAL  = '0,
    localparam int unsigned       ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en_i,
    input  logic [ADDR_W-1:0]            wr_addr_i,
    input  logic [DATA_W-1:0]            wr_data_i,
    input  logic                         commit_i,
    input  logic                         sync_i,
    output logic [NUM_REGS*DATA_W-1:0]   active_o,
    output logic [NUM_REGS-1:0]          upd_o,
    output logic                         busy_o,
    output logic                         pend_o,
    input  logic [ADDR_W-1:0]            rd_addr_i,
    input  logic                         rd_sel_i,
    output logic [DATA_W-1:0]            rd_data_o
);

    typedef enum logic [0:0] {StIdle, StArmed} state_e;

    state_e               state_q;
    logic [DATA_W-1:0]    shadow_q [NUM_REGS];
    logic [DATA_W-1:0]    active_q [NUM_REGS];
    logic [NUM_REGS-1:0]  dirty_q, dirty_d;
    logic [NUM_REGS-1:0]  upd_q;
    logic                 busy_q;
    logic                 pend_q;

    logic [NUM_REGS-1:0]  wr_mask;
    logic [NUM_REGS-1:0]  xfer_mask;
    logic                 xfer;

    always_comb begin
        wr_mask = '0;
        if (wr_en_i && (32'(wr_addr_i) < NUM_REGS)) begin
            wr_mask[wr_addr_i] = 1'b1;
        end
        xfer      = (state_q == StArmed) && sync_i;
        xfer_mask = xfer ? dirty_q : '0;
        // A write on the transfer edge keeps its entry dirty for the next commit.
        dirty_d   = (dirty_q & ~xfer_mask) | wr_mask;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
            pend_q  <= 1'b0;
            upd_q   <= '0;
            dirty_q <= '0;
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                shadow_q[k] <= RST_VAL;
                active_q[k] <= RST_VAL;
            end
        end else begin
            case (state_q)
                StIdle: begin
                    if (commit_i) begin
                        state_q <= StArmed;
                        busy_q  <= 1'b1;
                    end
                end
                StArmed: begin
                    if (sync_i) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
            for (int k = 0; k < int'(NUM_REGS); k++) begin
                if (xfer_mask[k]) active_q[k] <= shadow_q[k];
                if (wr_mask[k])   shadow_q[k] <= wr_data_i;
            end
            dirty_q <= dirty_d;
            pend_q  <= |dirty_d;
            upd_q   <= xfer_mask;
        end
    end

    for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_flat
        assign active_o[g*DATA_W +: DATA_W] = active_q[g];
    end

    assign upd_o  = upd_q;
    assign busy_o = busy_q;
    assign pend_o = pend_q;

`ifdef DDS_REG_BANK_READBACK_EN
    logic [DATA_W-1:0] rd_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_q <= '0;
        end else if (32'(rd_addr_i) < NUM_REGS) begin
            rd_q <= rd_sel_i ? shadow_q[rd_addr_i] : active_q[rd_addr_i];
        end else begin
            rd_q <= '0;
        end
    end

    assign rd_data_o = rd_q;
`else
    logic unused_rd;
    assign unused_rd = ^{rd_addr_i, rd_sel_i};
    assign rd_data_o = '0;
`endif

endmodule
